byte_deserialiser: RTL and testbench

//   Upstream feeder for byte_switch. Assembles serial bits, qualified by a

---
 rtl/byte_deserialiser.sv | 112 +++++++++++
 tb/tb_byte_deserialiser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_deserialiser.sv
// Byte deserialiser: shifts strobed serial bits into bytes and presents
// each completed byte with an out_en window of HOLD_CYCLES cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   ser_in     serial data bit, used only when ser_valid=1
//   ser_valid  bit strobe, one bit accepted per high cycle
//   clear      drops the partial byte (shift register and bit count)
//   data_out   last completed byte, held until the next completion
//   out_en     high for HOLD_CYCLES cycles after each completion
//   bit_count  bits accepted into the current partial byte
//   overrun    sticky flag: a byte completed while out_en was high
module byte_deserialiser #(
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_valid,
    input  logic       clear,
    output logic [7:0] data_out,
    output logic       out_en,
    output logic [2:0] bit_count,
    output logic       overrun
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic [7:0] hold_q, hold_d;
    logic       ovr_q, ovr_d;

    logic [7:0] shifted;
    logic       accept;
    logic       complete;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[6:0], ser_in};
        end else begin
            shifted = {ser_in, shreg_q[7:1]};
        end
    end

    // clear overrides the strobe, so a bit arriving with clear never
    // counts and can never complete a byte.
    assign accept   = ser_valid && !clear;
    assign complete = accept && (cnt_q == 3'd7);

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        hold_d  = hold_q;
        ovr_d   = ovr_q;

        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (ser_valid) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + 3'd1;
        end

        // A completion takes priority over the window countdown, so a
        // byte landing on the drop edge keeps out_en high without a gap.
        if (complete) begin
            data_d = shifted;
            en_d   = 1'b1;
            hold_d = HOLD_RELOAD;
            if (en_q) begin
                ovr_d = 1'b1;
            end
        end else if (en_q) begin
            if (hold_q == 8'd0) begin
                en_d = 1'b0;
            end else begin
                hold_d = hold_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_en    = en_q;
    assign bit_count = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_byte_deserialiser.sv
// Self-checking bench for byte_deserialiser: a vector table for the
// MSB-first instance plus scoreboarded byte sequences on three instances.
module tb_byte_deserialiser;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       ser_valid;
    logic       clear;

    logic [7:0] dm, dl, dh;
    logic       em, el, eh;
    logic [2:0] cm, cl, ch;
    logic       om, ol, oh;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_deserialiser #(.MSB_FIRST(1'b1), .HOLD_CYCLES(4)) u_m (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .clear(clear), .data_out(dm), .out_en(em), .bit_count(cm),
        .overrun(om)
    );

    byte_deserialiser #(.MSB_FIRST(1'b0), .HOLD_CYCLES(4)) u_l (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .clear(clear), .data_out(dl), .out_en(el), .bit_count(cl),
        .overrun(ol)
    );

    byte_deserialiser #(.MSB_FIRST(1'b1), .HOLD_CYCLES(8)) u_h (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .clear(clear), .data_out(dh), .out_en(eh), .bit_count(ch),
        .overrun(oh)
    );

    typedef struct {
        bit         r;
        bit         v;
        bit         d;
        bit         c;
        logic [7:0] ed;
        bit         ee;
        logic [2:0] ec;
        bit         eo;
    } vec_t;

    typedef struct {
        logic [7:0] m;
        logic [7:0] l;
    } exp_t;

    vec_t tab[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input bit r, input bit v, input bit d, input bit c,
                       input logic [7:0] ed, input bit ee,
                       input logic [2:0] ec, input bit eo);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.c = c;
        x.ed = ed; x.ee = ee; x.ec = ec; x.eo = eo;
        tab.push_back(x);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    task automatic do_rst();
        rst = 1'b1; ser_valid = 1'b0; ser_in = 1'b0; clear = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_sb();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_data_m", dm, e.m);
            chk("sb_data_l", dl, e.l);
            chk("sb_data_h", dh, e.m);
            chk("sb_en_m", 8'(em), 8'd1);
        end
    endtask

    // Sends b on consecutive strobes, bit 7 first on the wire.
    task automatic send_byte(input logic [7:0] b, input bit hold_h);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            ser_valid = 1'b1; ser_in = b[i]; clear = 1'b0;
            if (i == 0) begin
                e.m = b; e.l = rev8(b);
                sb.push_back(e);
            end
            tick();
            if (hold_h) chk("b2b_en_h", 8'(eh), 8'd1);
            if (i == 0) pop_sb();
        end
        ser_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; clear = 1'b0;
        @(negedge clk);

        // Single byte 8'h01 with a 4-cycle window.
        add(1, 0, 0, 0, 8'h00, 0, 3'd0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 8'h00, 0, 3'(i + 1), 0);
        add(0, 1, 1, 0, 8'h01, 1, 3'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'h01, 1, 3'd0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 8'h01, 0, 3'd0, 0);

        // 8'hff with a gap after every strobe.
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                add(0, 1, 1, 0, 8'h01, 0, 3'(i + 1), 0);
                add(0, 0, 0, 0, 8'h01, 0, 3'(i + 1), 0);
            end else begin
                add(0, 1, 1, 0, 8'hff, 1, 3'd0, 0);
            end
        end
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'hff, 1, 3'd0, 0);
        add(0, 0, 0, 0, 8'hff, 0, 3'd0, 0);

        // Clear mid-byte with a live strobe, then 8'h80.
        add(1, 0, 0, 0, 8'h00, 0, 3'd0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 8'h00, 0, 3'(i + 1), 0);
        add(0, 1, 1, 1, 8'h00, 0, 3'd0, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd1, 0);
        for (int i = 1; i < 7; i++) add(0, 1, 0, 0, 8'h00, 0, 3'(i + 1), 0);
        add(0, 1, 0, 0, 8'h80, 1, 3'd0, 0);

        // Clear at bit_count 7 with a strobe: no completion.
        for (int i = 0; i < 7; i++)
            add(0, 1, 1, 0, 8'h80, (i < 3), 3'(i + 1), 0);
        add(0, 1, 1, 1, 8'h80, 0, 3'd0, 0);
        add(0, 0, 0, 0, 8'h80, 0, 3'd0, 0);

        for (int k = 0; k < tab.size(); k++) begin
            rst = tab[k].r; ser_valid = tab[k].v;
            ser_in = tab[k].d; clear = tab[k].c;
            tick();
            chk($sformatf("v%0d_data", k), dm, tab[k].ed);
            chk($sformatf("v%0d_en", k), 8'(em), 8'(tab[k].ee));
            chk($sformatf("v%0d_cnt", k), 8'(cm), 8'(tab[k].ec));
            chk($sformatf("v%0d_ovr", k), 8'(om), 8'(tab[k].eo));
        end
        rst = 1'b0; ser_valid = 1'b0; clear = 1'b0;

        // LSB-first: wire bits 1,1,1,1,1,1,1,0.
        do_rst();
        send_byte(8'hfe, 1'b0);
        chk("lsb_data", dl, 8'h7f);
        chk("lsb_ovr", 8'(ol), 8'd0);

        // Back-to-back: second completion lands on u_h's drop edge.
        do_rst();
        send_byte(8'h20, 1'b0);
        chk("b2b_first_h", dh, 8'h20);
        send_byte(8'h80, 1'b1);
        chk("b2b_ovr_h", 8'(oh), 8'd1);
        chk("b2b_ovr_m", 8'(om), 8'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("b2b_en_h_off", 8'(eh), 8'd0);
        chk("b2b_ovr_sticky", 8'(oh), 8'd1);
        chk("b2b_data_kept", dh, 8'h80);

        // Reset mid-byte and during the out_en window.
        do_rst();
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1; ser_in = 1'b1; tick();
        end
        chk("rst_pre_cnt", 8'(cm), 8'd3);
        rst = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
        tick();
        rst = 1'b0; ser_valid = 1'b0;
        chk("rst_mid_cnt", 8'(cm), 8'd0);
        chk("rst_mid_en", 8'(em), 8'd0);
        send_byte(8'hc3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_win_data", dm, 8'h00);
        chk("rst_win_en", 8'(em), 8'd0);
        chk("rst_win_en_h", 8'(eh), 8'd0);
        chk("rst_win_ovr", 8'(oh), 8'd0);
        send_byte(8'ha5, 1'b0);
        chk("rst_after_cnt", 8'(cm), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
